// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side request/response handshakes and the unified memory port.
// master: arbiter side. slave: pipeline stages plus memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    logic        arb_err;
    logic        stall_req;

    logic        mport_ce;
    logic        mport_we;
    logic [31:0] mport_addr;
    logic [3:0]  mport_sel;
    logic [31:0] mport_wdata;
    logic [31:0] mport_rdata;

    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, mport_rdata,
        output if_done, if_inst, mem_done, mem_rdata, arb_err, stall_req,
               mport_ce, mport_we, mport_addr, mport_sel, mport_wdata
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, mport_rdata,
        input  if_done, if_inst, mem_done, mem_rdata, arb_err, stall_req,
               mport_ce, mport_we, mport_addr, mport_sel, mport_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data with fixed latency, data priority and fetch
// starvation guard. Optional misalignment rejection: define MEM_ARB_MISALIGN_CHK_EN.
module mem_port_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    mem_port_arbiter_if.master      bus
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic            own_data_q, own_data_d;
    logic [31:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            err_q, err_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     if_inst_q, if_inst_d;
    logic [31:0]     mem_rdata_q, mem_rdata_d;

    logic            grant_data;
    logic            reject;
    logic            if_done, mem_done, arb_err;
    logic            ce, we;
    logic [31:0]     maddr, mwdata;
    logic [3:0]      msel;

`ifdef MEM_ARB_MISALIGN_CHK_EN
    function automatic logic misaligned(input logic is_data, input logic [31:0] a,
                                        input logic [3:0] s);
        if (!is_data)                      return a[1:0] != 2'b00;
        if (s == 4'b1111)                  return a[1:0] != 2'b00;
        if (s == 4'b0011 || s == 4'b1100)  return a[0];
        return 1'b0;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        own_data_d  = own_data_q;
        addr_d      = addr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        err_d       = err_q;
        starve_d    = starve_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        ce          = 1'b0;
        we          = 1'b0;
        maddr       = '0;
        msel        = '0;
        mwdata      = '0;
        if_done     = 1'b0;
        mem_done    = 1'b0;
        arb_err     = 1'b0;
        reject      = 1'b0;
        // Data wins a tie unless fetch has been passed over STARVE_MAX times in a row.
        grant_data  = bus.mem_req & (~bus.if_req | (starve_q != SW'(STARVE_MAX)));

        case (state_q)
            IDLE: begin
                if (bus.if_req | bus.mem_req) begin
                    own_data_d = grant_data;
                    if (grant_data) begin
                        addr_d  = bus.mem_addr;
                        we_d    = bus.mem_we;
                        sel_d   = bus.mem_sel;
                        wdata_d = bus.mem_wdata;
                        if (bus.if_req && starve_q != SW'(STARVE_MAX))
                            starve_d = starve_q + SW'(1);
                    end else begin
                        addr_d   = bus.if_addr;
                        we_d     = 1'b0;
                        sel_d    = 4'b1111;
                        wdata_d  = '0;
                        starve_d = '0;
                    end
`ifdef MEM_ARB_MISALIGN_CHK_EN
                    reject = misaligned(grant_data, addr_d, sel_d);
`endif
                    cnt_d   = CW'(LATENCY - 1);
                    first_d = 1'b1;
                    err_d   = reject;
                    if (reject) begin
                        state_d = RESP;
                        if (grant_data) mem_rdata_d = '0;
                        else            if_inst_d   = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                ce      = 1'b1;
                // Write strobe only on the first beat so a store lands exactly once.
                we      = we_q & first_q;
                maddr   = addr_q;
                msel    = sel_q;
                mwdata  = wdata_q;
                first_d = 1'b0;
                if (cnt_q == '0) begin
                    if (own_data_d) mem_rdata_d = we_q ? 32'h0 : bus.mport_rdata;
                    else            if_inst_d   = bus.mport_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if_done  = ~own_data_q;
                mem_done = own_data_q;
                arb_err  = err_q;
                err_d    = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            own_data_q  <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_data_q  <= own_data_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.if_done     = if_done;
    assign bus.if_inst     = if_inst_q;
    assign bus.mem_done    = mem_done;
    assign bus.mem_rdata   = mem_rdata_q;
`ifdef MEM_ARB_MISALIGN_CHK_EN
    assign bus.arb_err     = arb_err;
`else
    assign bus.arb_err     = 1'b0;
`endif
    assign bus.mport_ce    = ce;
    assign bus.mport_we    = we;
    assign bus.mport_addr  = maddr;
    assign bus.mport_sel   = msel;
    assign bus.mport_wdata = mwdata;
    assign bus.stall_req   = (bus.if_req & ~if_done) | (bus.mem_req & ~mem_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2, STARVE_MAX=4, byte-lane memory model.
module tb_mem_port_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus_if();

    mem_port_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [31:0] mem [0:255];
    int cyc = 0;
    int put_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;

    assign bus_if.mport_rdata = mem[bus_if.mport_addr[9:2]];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus_if.mport_ce && bus_if.mport_we) begin
            for (int b = 0; b < 4; b++)
                if (bus_if.mport_sel[b])
                    mem[bus_if.mport_addr[9:2]][8*b +: 8] = bus_if.mport_wdata[8*b +: 8];
            if (bus_if.mport_addr == 32'h104 && bus_if.mport_sel[0]) put_cnt = put_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit data, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data ? bus_if.mem_done : bus_if.if_done) begin
                at = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, at, nm, ce_seen;
        logic err_s;
        logic [31:0] rd_s;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'h11223344;
        mem[2] = 32'h00A00093;
        mem[8] = 32'hDEADBEEF;
        mem[9] = 32'h12345678;
        bus_if.if_req = 0; bus_if.if_addr = 0;
        bus_if.mem_req = 0; bus_if.mem_we = 0; bus_if.mem_addr = 0;
        bus_if.mem_sel = 0; bus_if.mem_wdata = 0;

        // reset state
        step(); step();
        @(negedge clk);
        chk("rst_ce", {31'h0, bus_if.mport_ce}, 32'h0);
        chk("rst_done", {30'h0, bus_if.if_done, bus_if.mem_done}, 32'h0);
        chk("rst_inst", bus_if.if_inst, 32'h0);
        chk("rst_stall", {31'h0, bus_if.stall_req}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // single fetch
        bus_if.if_addr = 32'h8; bus_if.if_req = 1;
        @(negedge clk);
        chk("f_T_stall", {31'h0, bus_if.stall_req}, 32'h1);
        chk("f_T_ce", {31'h0, bus_if.mport_ce}, 32'h0);
        step(); @(negedge clk);
        chk("f_T1_ce", {31'h0, bus_if.mport_ce}, 32'h1);
        chk("f_T1_addr", bus_if.mport_addr, 32'h8);
        chk("f_T1_sel_we", {27'h0, bus_if.mport_sel, bus_if.mport_we}, {27'h0, 4'hF, 1'b0});
        step(); @(negedge clk);
        chk("f_T2_ce", {31'h0, bus_if.mport_ce}, 32'h1);
        chk("f_T2_done", {31'h0, bus_if.if_done}, 32'h0);
        step(); @(negedge clk);
        chk("f_T3_done", {31'h0, bus_if.if_done}, 32'h1);
        chk("f_T3_inst", bus_if.if_inst, 32'h00A00093);
        chk("f_T3_ce", {31'h0, bus_if.mport_ce}, 32'h0);
        chk("f_T3_stall", {31'h0, bus_if.stall_req}, 32'h0);
        step(); bus_if.if_req = 0;
        @(negedge clk);
        chk("f_T4_done", {31'h0, bus_if.if_done}, 32'h0);
        chk("f_T4_inst_hold", bus_if.if_inst, 32'h00A00093);

        // load
        step();
        bus_if.mem_req = 1; bus_if.mem_we = 0; bus_if.mem_addr = 32'h20; bus_if.mem_sel = 4'hF;
        t = cyc;
        wait_done(1, at);
        chk("ld_lat", at, t + 3);
        chk("ld_data", bus_if.mem_rdata, 32'hDEADBEEF);
        chk("ld_err", {31'h0, bus_if.arb_err}, 32'h0);
        step(); bus_if.mem_req = 0;

        // store exactly once
        step();
        bus_if.mem_req = 1; bus_if.mem_we = 1; bus_if.mem_addr = 32'h104;
        bus_if.mem_sel = 4'b0001; bus_if.mem_wdata = 32'h41;
        @(negedge clk);
        chk("st_T_ce", {31'h0, bus_if.mport_ce}, 32'h0);
        step(); @(negedge clk);
        chk("st_T1_we", {31'h0, bus_if.mport_we}, 32'h1);
        chk("st_T1_bus", {bus_if.mport_addr[15:0], 4'h0, bus_if.mport_sel, bus_if.mport_wdata[7:0]},
            {16'h0104, 4'h0, 4'b0001, 8'h41});
        step(); @(negedge clk);
        chk("st_T2_ce_we", {30'h0, bus_if.mport_ce, bus_if.mport_we}, 32'h2);
        step(); @(negedge clk);
        chk("st_T3_done", {31'h0, bus_if.mem_done}, 32'h1);
        chk("st_T3_rdata", bus_if.mem_rdata, 32'h0);
        step(); bus_if.mem_req = 0; bus_if.mem_we = 0;
        step(); step();
        chk("st_once", put_cnt, 1);
        chk("st_mem", mem[65], 32'h41);

        // contention: data first, fetch in the IDLE after mem_done
        step();
        bus_if.if_addr = 32'h8; bus_if.if_req = 1;
        bus_if.mem_addr = 32'h24; bus_if.mem_sel = 4'hF; bus_if.mem_req = 1;
        t = cyc;
        wait_done(1, at);
        chk("ct_mem_at", at, t + 3);
        chk("ct_mem_data", bus_if.mem_rdata, 32'h12345678);
        step(); bus_if.mem_req = 0;
        wait_done(0, at);
        chk("ct_if_at", at, t + 2 * (LAT + 2) - 1);
        chk("ct_if_inst", bus_if.if_inst, 32'h00A00093);
        step(); bus_if.if_req = 0;

        // starvation: two rounds, each four data dones then a fetch
        step();
        bus_if.mem_addr = 32'h20; bus_if.mem_req = 1; bus_if.if_req = 1;
        for (int r = 0; r < 2; r++) begin
            nm = 0; at = -1;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (bus_if.mem_done) nm++;
                if (bus_if.if_done) begin at = cyc; break; end
                @(posedge clk); #1;
            end
            chk($sformatf("sv_round%0d_memdones", r), nm, SMAX);
            chk($sformatf("sv_round%0d_fetch", r), {31'h0, at != -1}, 32'h1);
        end
        step(); bus_if.if_req = 0; bus_if.mem_req = 0;
        chk("sv_rdata", bus_if.mem_rdata, 32'hDEADBEEF);

        // reset during the second ACCESS cycle of a load
        step();
        bus_if.mem_addr = 32'h24; bus_if.mem_req = 1;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("rs_ce", {31'h0, bus_if.mport_ce}, 32'h0);
        chk("rs_addr", bus_if.mport_addr, 32'h0);
        @(negedge clk);
        chk("rs_done", {30'h0, bus_if.if_done, bus_if.mem_done}, 32'h0);
        chk("rs_rdata", bus_if.mem_rdata, 32'h0);
        bus_if.mem_req = 0;
        step(); step();
        rst_n = 1'b1;
        nm = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_if.mem_done || bus_if.mport_ce) nm++;
        end
        chk("rs_quiet", nm, 0);
        step();
        bus_if.mem_req = 1;
        t = cyc;
        wait_done(1, at);
        chk("rs_retry_at", at, t + 3);
        chk("rs_retry_data", bus_if.mem_rdata, 32'h12345678);
        step(); bus_if.mem_req = 0;

        // misaligned word load
        step();
        bus_if.mem_addr = 32'h6; bus_if.mem_sel = 4'hF; bus_if.mem_we = 0; bus_if.mem_req = 1;
        t = cyc; ce_seen = 0; at = -1; err_s = 1'bx; rd_s = 32'hx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.mport_ce) ce_seen = 1;
            if (bus_if.mem_done) begin
                at = cyc; err_s = bus_if.arb_err; rd_s = bus_if.mem_rdata;
                break;
            end
            @(posedge clk); #1;
        end
`ifdef MEM_ARB_MISALIGN_CHK_EN
        chk("ma_at", at, t + 1);
        chk("ma_err", {31'h0, err_s}, 32'h1);
        chk("ma_ce", ce_seen, 0);
        chk("ma_rdata", rd_s, 32'h0);
`else
        chk("ma_at", at, t + 3);
        chk("ma_err", {31'h0, err_s}, 32'h0);
        chk("ma_ce", ce_seen, 1);
        chk("ma_rdata", rd_s, 32'h11223344);
`endif
        step(); bus_if.mem_req = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
